// File: rtl/if_stage.sv
// Instruction fetch stage: variable-latency memory handshake, one-word skid
// buffer for decode back-pressure, and redirect handling with in-flight discard.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    localparam logic [1:0] FETCH   = 2'b00;
    localparam logic [1:0] HOLD    = 2'b01;
    localparam logic [1:0] DISCARD = 2'b10;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_bufInstr;
    logic [31:0] r_bufPc;
    logic [31:0] r_instruction;
    logic [31:0] r_pcOut;
    logic [31:0] r_pcPlus4;
    logic        r_valid;

    logic        w_slotFree;
    logic        w_consume;
    logic [31:0] w_pcNext;
    logic [31:0] w_redirectPc;

    assign w_slotFree   = ~r_valid | ~i_stall;
    assign w_consume    = r_valid & ~i_stall;
    assign w_pcNext     = r_pc + 32'd4;
    assign w_redirectPc = {i_redirect_target[31:2], 2'b00};

    // Request is masked during reset so an abandoned transaction is not re-driven.
    assign o_imem_req    = ~i_rst & (r_state != HOLD);
    assign o_imem_addr   = r_pc;
    assign o_instruction = r_instruction;
    assign o_pc_out      = r_pcOut;
    assign o_pc_plus4    = r_pcPlus4;
    assign o_valid       = r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC_ALIGNED;
            r_bufInstr    <= 32'h0000_0000;
            r_bufPc       <= 32'h0000_0000;
            r_instruction <= 32'h0000_0000;
            r_pcOut       <= 32'h0000_0000;
            r_pcPlus4     <= 32'h0000_0000;
            r_valid       <= 1'b0;
        end else if (i_redirect) begin
            // Any ack this cycle belongs to the old path and is dropped.
            r_pc    <= w_redirectPc;
            r_valid <= 1'b0;
            if (r_state == HOLD || i_imem_ack) begin
                r_state <= FETCH;
            end else begin
                r_state <= DISCARD;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (i_imem_ack && w_slotFree) begin
                        r_instruction <= i_imem_rdata;
                        r_pcOut       <= r_pc;
                        r_pcPlus4     <= w_pcNext;
                        r_valid       <= 1'b1;
                        r_pc          <= w_pcNext;
                    end else if (i_imem_ack) begin
                        r_bufInstr <= i_imem_rdata;
                        r_bufPc    <= r_pc;
                        r_pc       <= w_pcNext;
                        r_state    <= HOLD;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        r_instruction <= r_bufInstr;
                        r_pcOut       <= r_bufPc;
                        r_pcPlus4     <= r_bufPc + 32'd4;
                        r_valid       <= 1'b1;
                        r_state       <= FETCH;
                    end
                end
                DISCARD: begin
                    if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                    if (i_imem_ack) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of the requested word.
REQ-007 imem_ack  input  1  memory returns data this cycle; variable latency, 0..N cycles after request.
REQ-008 imem_rdata  input  32  instruction word, valid only with imem_ack.
REQ-009 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-010 redirect  input  1  branch/jump taken; refetch from redirect_target.
REQ-011 redirect_target  input  32  new fetch address.
REQ-012 instruction  output  32  registered instruction to decode.
REQ-013 pc_out  output  32  address of the instruction.
REQ-014 pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-015 valid  output  1  instruction/pc_out hold a live instruction.

Function
REQ-016 Internal pc register: next fetch address, always word aligned.
REQ-017 Internal buf register: one-word skid buffer holding instruction and address.
REQ-018 FSM states: FETCH, HOLD, DISCARD.
REQ-019 imem_req = 1 in FETCH and DISCARD, 0 in HOLD; imem_addr = pc, combinational from state and pc.
REQ-020 Once imem_req is asserted, imem_req and imem_addr stay stable until imem_ack, except in DISCARD (REQ-027).
REQ-021 Output is consumed on any cycle with valid=1 and stall=0.
REQ-022 FETCH, imem_ack=1, no redirect, and the output slot is free (valid=0 or stall=0): instruction<=imem_rdata, pc_out<=pc, pc_plus4<=pc+4, valid<=1, pc<=pc+4; FSM stays in FETCH.
REQ-023 FETCH, imem_ack=1, no redirect, and the slot is busy (valid=1 and stall=1): buf<=imem_rdata/pc, pc<=pc+4; FSM goes to HOLD.
REQ-024 HOLD with stall=0: buf moves to the outputs, valid stays 1; FSM goes to FETCH. HOLD with stall=1: everything holds.
REQ-025 No load and the output is consumed: valid<=0; instruction, pc_out and pc_plus4 keep their last values.
REQ-026 redirect has priority over all other events in every state. It sets pc<=redirect_target with bits [1:0] forced to 00 and sets valid<=0. It drops any buf contents.
REQ-027 Redirect without imem_ack in FETCH or DISCARD: FSM goes to DISCARD. In DISCARD, imem_req stays 1 but imem_addr may change to the new pc.
REQ-028 Redirect with imem_ack in FETCH: returned data is dropped; FSM goes to FETCH at the new pc.
REQ-029 Redirect in HOLD: FSM goes to FETCH.
REQ-030 DISCARD with imem_ack: data is dropped, valid stays 0; FSM goes to FETCH.
REQ-031 Redirect in DISCARD updates pc again; FSM stays in DISCARD until imem_ack.
REQ-032 pc increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-033 Fetch-to-valid latency is one cycle after imem_ack; zero-wait memory gives one instruction per cycle.

Reset
REQ-034 While rst=1: pc=RESET_PC, FSM=FETCH, valid=0, instruction=32'h0000_0000, pc_out=0, pc_plus4=0, buf cleared.
REQ-035 imem_req is 0 while rst=1 and goes to 1 in the first cycle after release.
REQ-036 Reset asserted mid-transaction abandons the outstanding request; an imem_ack arriving after release with no request is ignored.

Verification
REQ-037 Zero-wait memory, ack every cycle from reset -> valid rises 1 cycle after first ack; pc_out = 0,4,8,12 on consecutive cycles; pc_plus4 = 4,8,12,16.
REQ-038 Ack 3 cycles late for address 0x10 -> imem_addr holds 0x10 for 3 cycles; valid=0 until the cycle after ack.
REQ-039 stall=1 for 4 cycles while valid=1 and a second ack arrives -> FSM enters HOLD, imem_req=0, output unchanged; stall release -> buffered word appears next cycle, no word lost or duplicated.
REQ-040 redirect to 0x0000_0103 while a request is outstanding -> DISCARD; the late ack's data is never shown valid; next request address = 0x0000_0100.
REQ-041 Redirect and imem_ack in the same cycle, and redirect during HOLD -> valid=0 next cycle; next imem_addr = target; buffered word is dropped.
REQ-042 pc at 0xFFFF_FFFC with ack -> pc_plus4 = 0x0000_0000 and the next imem_addr = 0x0000_0000; rst pulsed mid-wait -> all outputs return to reset values asynchronously.
